// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with back-to-back word support
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             d_out,
    output logic             frame,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0] r_cnt;
    logic w_shift, w_last, w_accept;
    assign w_shift = (r_state == SHIFT);
    assign w_last = w_shift && (r_cnt == '0);
    assign w_accept = load_valid && load_ready;
    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else r_state <= w_next;
    end
    // shift register and bit counter; counter parks at zero instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_shreg <= data_in;
            r_cnt <= CW'(WIDTH - 1);
        end else if (w_shift) begin
            r_shreg <= LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
            r_cnt <= w_last ? '0 : r_cnt - CW'(1);
        end
    end
    // next state: the last-bit cycle either reloads or returns to idle
    always_comb begin
        w_next = r_state;
        if (!w_shift && w_accept) w_next = SHIFT;
        if (w_last) w_next = w_accept ? SHIFT : IDLE;
    end
    // outputs derived from registered state only
    always_comb begin
        load_ready = !w_shift || w_last;
        frame = w_shift;
        done = w_last;
        d_out = w_shift && (LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1]);
    end
endmodule
